regfile_wb_arbiter: RTL and testbench

- Writeback arbiter that drives the single register-file write port (`w_en`/`w_rn`/`w_data`) from several execution-unit result streams, e.g. ALU, load unit, mul/div.
- Each source has a valid/ready handshake into a one-entry holding buffer.
- A round-robin arbiter drains one buffer per cycle into registered write-port outputs.
- Also reports in-flight destination registers so issue logic can stall on RAW hazards.

---
 rtl/regfile_wb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Writeback arbiter for the single register-file write port. Each execution
//   unit (source) delivers results through a valid/ready handshake into its own
//   one-entry holding buffer. A round-robin arbiter drains one occupied buffer
//   per cycle into the registered write port. The block also answers a RAW
//   hazard query: whether a register still has an un-retired write in flight.
//
// Parameters:
//   NUM_SRC    number of result sources (2..8). Source 0 is the ALU by
//              convention; arbitration treats all sources identically.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   src_valid  per-source result valid
//   src_ready  per-source accept (combinational)
//   src_rn     per-source destination register, source k at [6k+5:6k]
//   src_data   per-source result, source k at [64k+63:64k]
//   w_en       register-file write enable (registered)
//   w_rn       register-file write index (registered)
//   w_data     register-file write data (registered)
//   q_rn       hazard query register number
//   q_pending  q_rn has a write in a buffer or on the write port (combinational)
//   wb_busy    any buffer occupied or a write on the port (combinational)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NUM_SRC = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [6*NUM_SRC-1:0]    src_rn,
  input  logic [64*NUM_SRC-1:0]   src_data,
  output logic                    w_en,
  output logic [5:0]              w_rn,
  output logic [63:0]             w_data,
  input  logic [5:0]              q_rn,
  output logic                    q_pending,
  output logic                    wb_busy
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Holding buffers, one entry per source.
  logic [NUM_SRC-1:0] buf_v_q, buf_v_d;
  logic [5:0]         buf_rn_q   [NUM_SRC];
  logic [5:0]         buf_rn_d   [NUM_SRC];
  logic [63:0]        buf_data_q [NUM_SRC];
  logic [63:0]        buf_data_d [NUM_SRC];

  // Round-robin search start.
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Registered write port.
  logic               w_en_q, w_en_d;
  logic [5:0]         w_rn_q, w_rn_d;
  logic [63:0]        w_data_q, w_data_d;

  // Arbitration result for the current cycle.
  logic [NUM_SRC-1:0] grant;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;

  logic [NUM_SRC-1:0] transfer;

  // Round-robin search: walk the buffers starting at rr_ptr, wrapping modulo
  // NUM_SRC, and grant the first occupied one. The wrap is done on an int so
  // non-power-of-two source counts work.
  always_comb begin : arb_search
    int               idx;
    logic [PTR_W-1:0] idx_w;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      idx_w = PTR_W'(idx);
      if (!grant_any && buf_v_q[idx_w]) begin
        grant[idx_w] = 1'b1;
        grant_any    = 1'b1;
        grant_idx    = idx_w;
      end
    end
  end

  // A source may hand over a result when its buffer is empty or is being
  // drained this cycle, which gives one result per cycle for a lone source.
  always_comb begin
    src_ready = ~buf_v_q | grant;
    transfer  = src_valid & src_ready;
  end

  // Buffer next state. A load takes priority over the grant-clear so that a
  // drain and refill in the same cycle leaves the buffer valid with the new
  // result. Results for r0 are accepted but never stored.
  always_comb begin
    buf_v_d    = buf_v_q;
    buf_rn_d   = buf_rn_q;
    buf_data_d = buf_data_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (transfer[k] && (src_rn[6*k +: 6] != 6'd0)) begin
        buf_v_d[k]    = 1'b1;
        buf_rn_d[k]   = src_rn[6*k +: 6];
        buf_data_d[k] = src_data[64*k +: 64];
      end else if (grant[k]) begin
        buf_v_d[k] = 1'b0;
      end
    end
  end

  // Write port and pointer next state. Index/data hold when idle so the port
  // only changes on an actual write.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    w_en_d   = 1'b0;
    w_rn_d   = w_rn_q;
    w_data_d = w_data_q;
    if (grant_any) begin
      w_en_d   = 1'b1;
      w_rn_d   = buf_rn_q[grant_idx];
      w_data_d = buf_data_q[grant_idx];
      if (grant_idx == PTR_W'(NUM_SRC - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + PTR_W'(1);
      end
    end
  end

  // Hazard query. The write-port term matters because the register file only
  // captures that write at the end of the current cycle.
  always_comb begin : hazard_query
    logic hit;
    hit = w_en_q && (w_rn_q == q_rn);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (buf_v_q[k] && (buf_rn_q[k] == q_rn)) begin
        hit = 1'b1;
      end
    end
    q_pending = (q_rn != 6'd0) && hit;
    wb_busy   = (|buf_v_q) || w_en_q;
  end

  // All state. Reset drops buffered results and the pending write at once,
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v_q  <= '0;
      rr_ptr_q <= '0;
      w_en_q   <= 1'b0;
      w_rn_q   <= 6'd0;
      w_data_q <= 64'd0;
      for (int k = 0; k < NUM_SRC; k++) begin
        buf_rn_q[k]   <= 6'd0;
        buf_data_q[k] <= 64'd0;
      end
    end else begin
      buf_v_q  <= buf_v_d;
      rr_ptr_q <= rr_ptr_d;
      w_en_q   <= w_en_d;
      w_rn_q   <= w_rn_d;
      w_data_q <= w_data_d;
      for (int k = 0; k < NUM_SRC; k++) begin
        buf_rn_q[k]   <= buf_rn_d[k];
        buf_data_q[k] <= buf_data_d[k];
      end
    end
  end

  assign w_en   = w_en_q;
  assign w_rn   = w_rn_q;
  assign w_data = w_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Drives directed scenarios and randomized traffic into regfile_wb_arbiter
// and compares every output against a behavioural model every cycle.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [6*N-1:0]  src_rn;
  logic [64*N-1:0] src_data;
  logic            w_en;
  logic [5:0]      w_rn;
  logic [63:0]     w_data;
  logic [5:0]      q_rn;
  logic            q_pending;
  logic            wb_busy;

  regfile_wb_arbiter #(.NUM_SRC(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_rn    (src_rn),
    .src_data  (src_data),
    .w_en      (w_en),
    .w_rn      (w_rn),
    .w_data    (w_data),
    .q_rn      (q_rn),
    .q_pending (q_pending),
    .wb_busy   (wb_busy)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  // Behavioural model: a one-slot mailbox per source, the index the next
  // search starts from, and what the write port currently shows.
  bit          mv    [N];
  logic [5:0]  mrn   [N];
  logic [63:0] mdata [N];
  int          mrr;
  bit          mwen;
  logic [5:0]  mwrn;
  logic [63:0] mwdata;

  // Per-cycle observation log used by the literal checks of directed tests.
  logic         obs_wen  [64];
  logic [5:0]   obs_rn   [64];
  logic [63:0]  obs_data [64];
  logic         obs_qp   [64];
  logic         obs_busy [64];
  logic [N-1:0] obs_rdy  [64];
  logic [1:0]   obs_rr   [64];
  logic [5:0]   wlog[$];

  // Winner is the occupied mailbox closest to the start index going upward.
  function automatic int model_winner();
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int k = 0; k < N; k++) begin
      if (mv[k]) begin
        d = (k - mrr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < N; k++) begin
      mv[k]    = 1'b0;
      mrn[k]   = 6'd0;
      mdata[k] = 64'd0;
    end
    mrr    = 0;
    mwen   = 1'b0;
    mwrn   = 6'd0;
    mwdata = 64'd0;
  endtask

  task automatic modelStep();
    int           w;
    logic [N-1:0] acc;
    w = model_winner();
    for (int k = 0; k < N; k++) begin
      acc[k] = src_valid[k] && (!mv[k] || (w == k));
    end
    if (w >= 0) begin
      mwen   = 1'b1;
      mwrn   = mrn[w];
      mwdata = mdata[w];
      mv[w]  = 1'b0;
      mrr    = (w + 1) % N;
    end else begin
      mwen = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      if (acc[k] && (src_rn[6*k +: 6] != 6'd0)) begin
        mv[k]    = 1'b1;
        mrn[k]   = src_rn[6*k +: 6];
        mdata[k] = src_data[64*k +: 64];
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    int           w;
    logic [N-1:0] exp_rdy;
    logic         hit, busy;
    w    = model_winner();
    hit  = mwen && (mwrn == q_rn);
    busy = mwen;
    for (int k = 0; k < N; k++) begin
      exp_rdy[k] = !mv[k] || (w == k);
      if (mv[k]) begin
        busy = 1'b1;
        if (mrn[k] == q_rn) hit = 1'b1;
      end
    end
    checkVal("src_ready", 64'(src_ready), 64'(exp_rdy));
    checkVal("w_en", 64'(w_en), 64'(mwen));
    checkVal("w_rn", 64'(w_rn), 64'(mwrn));
    checkVal("w_data", w_data, mwdata);
    checkVal("q_pending", 64'(q_pending), 64'((q_rn != 6'd0) && hit));
    checkVal("wb_busy", 64'(wb_busy), 64'(busy));
    if (cyc < 64) begin
      obs_wen[cyc]  = w_en;
      obs_rn[cyc]   = w_rn;
      obs_data[cyc] = w_data;
      obs_qp[cyc]   = q_pending;
      obs_busy[cyc] = wb_busy;
      obs_rdy[cyc]  = src_ready;
      obs_rr[cyc]   = dut.rr_ptr_q;
    end
    if (w_en) wlog.push_back(w_rn);
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [6*N-1:0] rn,
                               input logic [64*N-1:0] data, input logic [5:0] qrn);
    src_valid = v;
    src_rn    = rn;
    src_data  = data;
    q_rn      = qrn;
  endtask

  // One clock: compare just after the falling edge, advance the model at the
  // rising edge, and return at the next falling edge ready for new inputs.
  task automatic cycle();
    #1;
    checkOutput();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    cyc++;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus('0, '0, '0, 6'd0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    wlog.delete();
  endtask

  initial begin
    logic         all_rdy0;
    logic [6*N-1:0]  rnv;
    logic [64*N-1:0] dv;
    logic [N-1:0]    vv;

    rst_n = 1'b0;
    applyStimulus('0, '0, '0, 6'd0);
    modelReset();
    @(negedge clk);
    #1;
    checkVal("reset w_en", 64'(w_en), 64'd0);
    checkVal("reset src_ready", 64'(src_ready), 64'b111);
    checkVal("reset w_data", w_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Single uncontended result from source 1.
    $display("[TB] single result latency");
    for (int c = 0; c < 8; c++) begin
      if (c == 3) applyStimulus(3'b010, {6'd0, 6'd5, 6'd0}, {64'd0, 64'hDEAD_BEEF_0000_0001, 64'd0}, 6'd5);
      else        applyStimulus('0, '0, '0, 6'd5);
      cycle();
    end
    checkVal("t1 w_en c4", 64'(obs_wen[4]), 64'd0);
    checkVal("t1 w_en c5", 64'(obs_wen[5]), 64'd1);
    checkVal("t1 w_rn c5", 64'(obs_rn[5]), 64'd5);
    checkVal("t1 w_data c5", obs_data[5], 64'hDEAD_BEEF_0000_0001);
    checkVal("t1 q_pending c4", 64'(obs_qp[4]), 64'd1);
    checkVal("t1 q_pending c5", 64'(obs_qp[5]), 64'd1);
    checkVal("t1 q_pending c6", 64'(obs_qp[6]), 64'd0);
    checkVal("t1 src_ready c3", 64'(obs_rdy[3]), 64'b111);

    // Back-to-back stream from source 0.
    $display("[TB] single source streaming");
    cyc = 0;
    wlog.delete();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) applyStimulus(3'b001, {12'd0, 6'(c + 1)}, {128'd0, 64'(10 + c)}, 6'd0);
      else       applyStimulus('0, '0, '0, 6'd0);
      cycle();
    end
    all_rdy0 = obs_rdy[0][0] & obs_rdy[1][0] & obs_rdy[2][0] & obs_rdy[3][0];
    checkVal("t2 src_ready0 held", 64'(all_rdy0), 64'd1);
    for (int c = 2; c < 6; c++) begin
      checkVal("t2 w_en", 64'(obs_wen[c]), 64'd1);
      checkVal("t2 w_rn", 64'(obs_rn[c]), 64'(c - 1));
      checkVal("t2 w_data", obs_data[c], 64'(c + 8));
    end
    checkVal("t2 w_en c6", 64'(obs_wen[6]), 64'd0);

    // All sources contending from a reset pointer.
    $display("[TB] three-way contention");
    applyReset();
    for (int c = 0; c < 12; c++) begin
      if (c < 6) applyStimulus(3'b111, {6'd9, 6'd8, 6'd7}, {64'd300, 64'd200, 64'd100}, 6'd8);
      else       applyStimulus('0, '0, '0, 6'd8);
      cycle();
    end
    checkVal("t3 write count", 64'(wlog.size() >= 6), 64'd1);
    if (wlog.size() >= 6) begin
      checkVal("t3 seq0", 64'(wlog[0]), 64'd7);
      checkVal("t3 seq1", 64'(wlog[1]), 64'd8);
      checkVal("t3 seq2", 64'(wlog[2]), 64'd9);
      checkVal("t3 seq3", 64'(wlog[3]), 64'd7);
      checkVal("t3 seq4", 64'(wlog[4]), 64'd8);
      checkVal("t3 seq5", 64'(wlog[5]), 64'd9);
    end
    checkVal("t3 ready c1", 64'(obs_rdy[1]), 64'b001);
    checkVal("t3 ready c2", 64'(obs_rdy[2]), 64'b010);
    checkVal("t3 ready c3", 64'(obs_rdy[3]), 64'b100);

    // r0 result is swallowed.
    $display("[TB] r0 discard");
    cyc = 0;
    wlog.delete();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) applyStimulus(3'b100, '0, {64'hFFFF, 128'd0}, 6'd0);
      else        applyStimulus('0, '0, '0, 6'd0);
      cycle();
    end
    checkVal("t4 ready2 c0", 64'(obs_rdy[0][2]), 64'd1);
    checkVal("t4 w_en c2", 64'(obs_wen[2]), 64'd0);
    checkVal("t4 busy c1", 64'(obs_busy[1]), 64'd0);
    checkVal("t4 q_pending c0", 64'(obs_qp[0]), 64'd0);
    checkVal("t4 writes", 64'(wlog.size()), 64'd0);

    // Asynchronous reset with results in flight.
    $display("[TB] reset mid-operation");
    cyc = 0;
    applyStimulus(3'b101, {6'd13, 6'd0, 6'd12}, {64'hD13, 64'd0, 64'hD12}, 6'd13);
    cycle();
    applyStimulus('0, '0, '0, 6'd13);
    cycle();
    #1;
    checkVal("t5 w_en before reset", 64'(w_en), 64'd1);
    checkVal("t5 busy before reset", 64'(wb_busy), 64'd1);
    checkVal("t5 q_pending before reset", 64'(q_pending), 64'd1);
    rst_n = 1'b0;
    #1;
    checkVal("t5 w_en in reset", 64'(w_en), 64'd0);
    checkVal("t5 busy in reset", 64'(wb_busy), 64'd0);
    checkVal("t5 q_pending in reset", 64'(q_pending), 64'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    wlog.delete();
    for (int c = 0; c < 10; c++) begin
      applyStimulus('0, '0, '0, (c % 2 == 0) ? 6'd12 : 6'd13);
      cycle();
    end
    checkVal("t5 writes after reset", 64'(wlog.size()), 64'd0);

    // Pointer rotation with two full buffers.
    $display("[TB] pointer rotation");
    cyc = 0;
    wlog.delete();
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      applyStimulus(3'b001, {12'd0, 6'd30}, {128'd0, 64'd1}, 6'd20);
      else if (c == 1) applyStimulus(3'b011, {6'd0, 6'd20, 6'd21}, {64'd0, 64'd2, 64'd3}, 6'd20);
      else             applyStimulus('0, '0, '0, 6'd21);
      cycle();
    end
    checkVal("t6 write count", 64'(wlog.size()), 64'd3);
    if (wlog.size() >= 3) begin
      checkVal("t6 seq0", 64'(wlog[0]), 64'd30);
      checkVal("t6 seq1", 64'(wlog[1]), 64'd20);
      checkVal("t6 seq2", 64'(wlog[2]), 64'd21);
    end
    checkVal("t6 rr_ptr c3", 64'(obs_rr[3]), 64'd2);

    // Randomized traffic in a few reset-separated segments.
    $display("[TB] random traffic");
    for (int s = 0; s < 3; s++) begin
      applyReset();
      for (int c = 0; c < 400; c++) begin
        for (int k = 0; k < N; k++) begin
          vv[k]          = ($urandom_range(0, 99) < 30 + 20 * s);
          rnv[6*k +: 6]  = 6'($urandom_range(0, 15));
          dv[64*k +: 64] = {$urandom, $urandom};
        end
        applyStimulus(vv, rnv, dv, 6'($urandom_range(0, 15)));
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
